// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and response codes used by the master, the slave
// and the bus interface.
`timescale 1ns/1ps
package axi_lite_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [1:0]  resp_t;
  typedef logic [3:0]  strb_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // The master only issues full-word writes.
  localparam strb_t STRB_ALL = 4'hF;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: five channels with master and slave views.
`timescale 1ns/1ps
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one user command in, one AXI
// read or write transaction out, slave response returned unmodified.
`timescale 1ns/1ps
module axi_lite_master
  import axi_lite_pkg::*;
(
  input  logic       aclk,
  input  logic       areset,
  axi_lite_if.master m_axi_lite,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  addr_t      cmd_addr,
  input  data_t      cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output data_t      rsp_rdata,
  output resp_t      rsp_resp,
  output logic       rsp_write
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RADDR = 3'd1;
  localparam logic [2:0] ST_RDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_WRESP = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  logic [2:0] state_q;
  logic [2:0] state_d;

  addr_t addr_q;
  data_t wdata_q;
  logic  write_q;
  logic  aw_done_q;
  logic  w_done_q;
  data_t rdata_q;
  resp_t resp_q;

  logic cmd_fire;
  logic ar_fire;
  logic r_fire;
  logic aw_fire;
  logic w_fire;
  logic b_fire;
  logic write_done;

  // Handshakes are qualified by registered state, so no AXI input reaches
  // an AXI output combinationally.
  assign cmd_fire   = (state_q == ST_IDLE)  && cmd_valid;
  assign ar_fire    = (state_q == ST_RADDR) && m_axi_lite.arready;
  assign r_fire     = (state_q == ST_RDATA) && m_axi_lite.rvalid;
  assign aw_fire    = (state_q == ST_WRITE) && !aw_done_q && m_axi_lite.awready;
  assign w_fire     = (state_q == ST_WRITE) && !w_done_q  && m_axi_lite.wready;
  assign b_fire     = (state_q == ST_WRESP) && m_axi_lite.bvalid;
  assign write_done = (state_q == ST_WRITE) &&
                      (aw_done_q || aw_fire) && (w_done_q || w_fire);

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_valid)  state_d = cmd_write ? ST_WRITE : ST_RADDR;
      ST_RADDR: if (ar_fire)    state_d = ST_RDATA;
      ST_RDATA: if (r_fire)     state_d = ST_RESP;
      ST_WRITE: if (write_done) state_d = ST_WRESP;
      ST_WRESP: if (b_fire)     state_d = ST_RESP;
      ST_RESP:  if (rsp_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      // NOTE: non-blocking assignments for all registered state so every flop sees pre-edge values.
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q <= state_d;

      if (cmd_fire) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
      end

      if (aw_fire) aw_done_q <= 1'b1;
      if (w_fire)  w_done_q  <= 1'b1;
      // Both flags clear as the write phase ends, ready for the next command.
      if (write_done) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end

      if (r_fire) begin
        rdata_q <= m_axi_lite.rdata;
        resp_q  <= m_axi_lite.rresp;
      end
      if (b_fire) begin
        rdata_q <= '0;
        resp_q  <= m_axi_lite.bresp;
      end
    end
  end

  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arvalid = (state_q == ST_RADDR);
  assign m_axi_lite.rready  = (state_q == ST_RDATA);
  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awvalid = (state_q == ST_WRITE) && !aw_done_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = STRB_ALL;
  assign m_axi_lite.wvalid  = (state_q == ST_WRITE) && !w_done_q;
  assign m_axi_lite.bready  = (state_q == ST_WRESP);

  // cmd_ready is gated by reset so nothing is accepted in the reset cycle.
  assign cmd_ready = (state_q == ST_IDLE) && !areset;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_write = write_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: a cycle-driven slave with
// programmable wait states, a directed vector table and randomized traffic.
`timescale 1ns/1ps
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic  aclk = 1'b0;
  logic  areset;
  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_write;
  addr_t cmd_addr;
  data_t cmd_wdata;
  logic  rsp_valid;
  logic  rsp_ready;
  data_t rsp_rdata;
  resp_t rsp_resp;
  logic  rsp_write;

  axi_lite_if bus ();

  axi_lite_master dut (
    .aclk       (aclk),
    .areset     (areset),
    .m_axi_lite (bus),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_write  (rsp_write)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic  wr;
    addr_t addr;
    data_t wdata;
    resp_t resp;
    int    ar_d;
    int    r_d;
    int    aw_d;
    int    w_d;
    int    b_d;
    int    rsp_d;
    logic  lat;
    data_t exp_rdata;
    resp_t exp_resp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  data_t model_mem [addr_t];
  data_t slave_mem [addr_t];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = RESP_OKAY;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = RESP_OKAY;
  endtask

  task automatic run_txn(input vec_t v);
    int    cyc, guard;
    int    ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit    ar_done, r_on, r_done, aw_done, w_done, b_on, b_done;
    bit    p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    addr_t p_araddr, p_awaddr, cap_aw;
    data_t p_wdata, cap_w, rd, hold_rdata;
    resp_t hold_resp;

    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt} = '0;
    {ar_done, r_on, r_done, aw_done, w_done, b_on, b_done} = '0;
    {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
    p_araddr = '0; p_awaddr = '0; cap_aw = '0;
    p_wdata = '0; cap_w = '0; rd = '0;

    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    @(negedge aclk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cyc = 1;

    while (!rsp_valid && cyc < 200) begin
      // Handshakes that completed on the edge just passed.
      if (p_arv && p_arr) begin
        ar_done = 1'b1;
        bus.arready = 1'b0;
        rd = slave_mem.exists(p_araddr) ? slave_mem[p_araddr] : '0;
        r_on = 1'b1;
      end
      if (p_rv && p_rr) begin
        r_done = 1'b1;
        bus.rvalid = 1'b0;
      end
      if (p_awv && p_awr) begin
        aw_done = 1'b1;
        bus.awready = 1'b0;
        cap_aw = p_awaddr;
      end
      if (p_wv && p_wr) begin
        w_done = 1'b1;
        bus.wready = 1'b0;
        cap_w = p_wdata;
      end
      if (aw_done && w_done && !b_on) begin
        slave_mem[cap_aw] = cap_w;
        b_on = 1'b1;
      end
      if (p_bv && p_br) begin
        b_done = 1'b1;
        bus.bvalid = 1'b0;
      end

      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (v.wr)
        check("read_chan_idle", 32'({bus.arvalid, bus.rready}), 32'd0);
      else
        check("write_chan_idle", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
      if (p_arv && !p_arr) begin
        check("arvalid_hold", 32'(bus.arvalid), 32'd1);
        check("araddr_stable", bus.araddr, p_araddr);
      end
      if (p_awv && !p_awr) begin
        check("awvalid_hold", 32'(bus.awvalid), 32'd1);
        check("awaddr_stable", bus.awaddr, p_awaddr);
      end
      if (p_wv && !p_wr) begin
        check("wvalid_hold", 32'(bus.wvalid), 32'd1);
        check("wdata_stable", bus.wdata, p_wdata);
      end
      if (bus.arvalid) check("araddr", bus.araddr, v.addr);
      if (bus.awvalid) check("awaddr", bus.awaddr, v.addr);
      if (bus.wvalid)  check("wdata", bus.wdata, v.wdata);
      if (aw_done) check("awvalid_drop", 32'(bus.awvalid), 32'd0);
      if (w_done)  check("wvalid_drop", 32'(bus.wvalid), 32'd0);
      check("bready_early", 32'(bus.bready && !(aw_done && w_done)), 32'd0);
      check("rready_early", 32'(bus.rready && !ar_done), 32'd0);
      if (v.lat && cyc == 1)
        check("valid_at_cyc1", v.wr ? 32'(bus.awvalid && bus.wvalid) : 32'(bus.arvalid), 32'd1);
      if (v.lat && cyc == 2)
        check("ready_at_cyc2", v.wr ? 32'(bus.bready) : 32'(bus.rready), 32'd1);

      // Slave drive for the coming edge.
      if (bus.arvalid && !ar_done) begin
        if (ar_cnt >= v.ar_d) bus.arready = 1'b1;
        else begin bus.arready = 1'b0; ar_cnt++; end
      end
      if (r_on && !r_done && !bus.rvalid) begin
        if (r_cnt >= v.r_d) begin
          bus.rvalid = 1'b1;
          bus.rdata  = rd;
          bus.rresp  = v.resp;
        end else r_cnt++;
      end
      if (bus.awvalid && !aw_done) begin
        if (aw_cnt >= v.aw_d) bus.awready = 1'b1;
        else begin bus.awready = 1'b0; aw_cnt++; end
      end
      if (bus.wvalid && !w_done) begin
        if (w_cnt >= v.w_d) bus.wready = 1'b1;
        else begin bus.wready = 1'b0; w_cnt++; end
      end
      if (b_on && !b_done && !bus.bvalid) begin
        if (b_cnt >= v.b_d) begin
          bus.bvalid = 1'b1;
          bus.bresp  = v.resp;
        end else b_cnt++;
      end

      p_arv = bus.arvalid; p_arr = bus.arready; p_araddr = bus.araddr;
      p_rv  = bus.rvalid;  p_rr  = bus.rready;
      p_awv = bus.awvalid; p_awr = bus.awready; p_awaddr = bus.awaddr;
      p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wdata  = bus.wdata;
      p_bv  = bus.bvalid;  p_br  = bus.bready;
      @(negedge aclk);
      cyc++;
    end

    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    slave_idle();
    if (!rsp_valid) return;
    check("final_handshake", v.wr ? 32'(p_bv && p_br) : 32'(p_rv && p_rr), 32'd1);
    if (v.lat) check("rsp_latency", 32'(cyc), 32'd3);
    check("rsp_write", 32'(rsp_write), 32'(v.wr));
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_resp", 32'(rsp_resp), 32'(v.exp_resp));

    hold_rdata = rsp_rdata;
    hold_resp  = rsp_resp;
    for (int i = 0; i < v.rsp_d; i++) begin
      @(negedge aclk);
      check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      check("rsp_rdata_hold", rsp_rdata, hold_rdata);
      check("rsp_resp_hold", 32'(rsp_resp), 32'(hold_resp));
      check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge aclk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  task automatic apply(input vec_t v);
    run_txn(v);
    if (v.wr) model_mem[v.addr] = v.wdata;
  endtask

  vec_t tbl [11];
  vec_t rv;

  initial begin
    areset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    slave_idle();

    //             wr    addr       wdata         resp         ar r aw w b rsp lat  exp_rdata     exp_resp
    tbl[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, RESP_OKAY,   0, 0, 0, 0, 0, 0, 1'b1, 32'h0,         RESP_OKAY};
    tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0,         RESP_OKAY,   0, 0, 0, 0, 0, 0, 1'b1, 32'hDEAD_BEEF, RESP_OKAY};
    tbl[2]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, RESP_OKAY,   0, 0, 3, 0, 0, 0, 1'b0, 32'h0,         RESP_OKAY};
    tbl[3]  = '{1'b0, 32'h0000_0008, 32'h0,         RESP_OKAY,   5, 4, 0, 0, 0, 3, 1'b0, 32'h1234_5678, RESP_OKAY};
    tbl[4]  = '{1'b1, 32'h0000_0100, 32'h0BAD_0BAD, RESP_SLVERR, 0, 0, 0, 0, 1, 0, 1'b0, 32'h0,         RESP_SLVERR};
    tbl[5]  = '{1'b1, 32'h0000_000C, 32'hA5A5_A5A5, RESP_OKAY,   0, 0, 0, 0, 0, 0, 1'b1, 32'h0,         RESP_OKAY};
    tbl[6]  = '{1'b0, 32'h0000_000C, 32'h0,         RESP_OKAY,   0, 0, 0, 0, 0, 0, 1'b1, 32'hA5A5_A5A5, RESP_OKAY};
    tbl[7]  = '{1'b0, 32'h0000_0040, 32'h0,         RESP_DECERR, 1, 2, 0, 0, 0, 1, 1'b0, 32'h0,         RESP_DECERR};
    tbl[8]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, RESP_EXOKAY, 0, 0, 0, 2, 3, 0, 1'b0, 32'h0,         RESP_EXOKAY};
    tbl[9]  = '{1'b1, 32'h0000_0014, 32'h0F0F_0F0F, RESP_OKAY,   0, 0, 2, 2, 0, 2, 1'b0, 32'h0,         RESP_OKAY};
    tbl[10] = '{1'b0, 32'h0000_0010, 32'h0,         RESP_OKAY,   2, 0, 0, 0, 0, 0, 1'b0, 32'hCAFE_F00D, RESP_OKAY};

    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_read_valids", 32'({bus.arvalid, bus.rready}), 32'd0);
    check("rst_write_valids", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_araddr", bus.araddr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_rsp_write", 32'(rsp_write), 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 11; i++) apply(tbl[i]);

    // Reset pulsed while the write waits for its response.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0200;
    cmd_wdata = 32'h55AA_55AA;
    @(negedge aclk);
    cmd_valid = 1'b0;
    check("mid_awvalid", 32'(bus.awvalid), 32'd1);
    check("mid_wvalid", 32'(bus.wvalid), 32'd1);
    bus.awready = 1'b1;
    bus.wready  = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    check("mid_in_wresp", 32'(bus.bready), 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_read_chan", 32'({bus.arvalid, bus.rready}), 32'd0);
    check("mid_rst_write_chan", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_araddr", bus.araddr, 32'd0);
    areset = 1'b0;
    @(negedge aclk);
    check("mid_rst_idle", 32'(cmd_ready), 32'd1);
    rv = '{1'b0, 32'h0000_0004, 32'h0, RESP_OKAY, 0, 0, 0, 0, 0, 0, 1'b1, 32'hDEAD_BEEF, RESP_OKAY};
    apply(rv);

    // Randomized traffic against the memory model.
    for (int n = 0; n < 40; n++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.addr  = addr_t'($urandom_range(0, 15)) << 2;
      rv.wdata = $urandom;
      rv.resp  = resp_t'($urandom_range(0, 3));
      rv.ar_d  = $urandom_range(0, 3);
      rv.r_d   = $urandom_range(0, 3);
      rv.aw_d  = $urandom_range(0, 3);
      rv.w_d   = $urandom_range(0, 3);
      rv.b_d   = $urandom_range(0, 3);
      rv.rsp_d = $urandom_range(0, 2);
      rv.lat   = (rv.ar_d == 0 && rv.r_d == 0 && rv.aw_d == 0 && rv.w_d == 0 && rv.b_d == 0);
      rv.exp_resp  = rv.resp;
      rv.exp_rdata = rv.wr ? '0 : (model_mem.exists(rv.addr) ? model_mem[rv.addr] : '0);
      apply(rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
